// File: rtl/axis_capture_arbiter.sv
// Round-robin packet arbiter that funnels NUM_PORTS AXI4-Stream sources into one capture sink.
// A grant is held for a whole packet; completed packets and overlength packets are tracked.
module axis_capture_arbiter #(
  parameter  int unsigned NUM_PORTS     = 4,
  parameter  int unsigned AXIS_WIDTH    = 64,
  parameter  int unsigned MAX_PKT_BEATS = 256,
  localparam int unsigned IDW           = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int unsigned SW            = AXIS_WIDTH / 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS*AXIS_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS*SW-1:0]         s_tstrb,
  input  logic [NUM_PORTS-1:0]            s_tvalid,
  input  logic [NUM_PORTS-1:0]            s_tlast,
  output logic [NUM_PORTS-1:0]            s_tready,
  output logic [AXIS_WIDTH-1:0]           m_tdata,
  output logic [SW-1:0]                   m_tstrb,
  output logic                            m_tvalid,
  output logic                            m_tlast,
  input  logic                            m_tready,
  output logic [IDW-1:0]                  m_tid,
  output logic [15:0]                     pkt_count,
  output logic                            overlength
);
  localparam int unsigned CW   = 16;
  localparam int unsigned SUMW = IDW + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [CW-1:0]  pkt_count_q, pkt_count_d;
  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
  logic           overlength_q, overlength_d;

  logic [NUM_PORTS-1:0]  valid_sh, last_sh;
  logic                  sel_valid, sel_last, xfer;
  logic [AXIS_WIDTH-1:0] sel_data;
  logic [SW-1:0]         sel_strb;

  // Signals of the currently granted port
  always_comb begin
    valid_sh  = s_tvalid >> grant_q;
    last_sh   = s_tlast >> grant_q;
    sel_valid = valid_sh[0];
    sel_last  = last_sh[0];
    sel_data  = AXIS_WIDTH'(s_tdata >> (32'(grant_q) * AXIS_WIDTH));
    sel_strb  = SW'(s_tstrb >> (32'(grant_q) * SW));
  end

  logic [2*NUM_PORTS-1:0] req_dbl;
  logic [NUM_PORTS-1:0]   req_scan;
  logic [IDW-1:0]         rr_off, rr_pick;
  logic [SUMW-1:0]        rr_sum;
  logic                   rr_found;

  // Rotate requests so bit 0 is the port after last_grant, then take the lowest set bit
  always_comb begin
    req_dbl  = {s_tvalid, s_tvalid} >> (SUMW'(last_grant_q) + SUMW'(1));
    req_scan = req_dbl[NUM_PORTS-1:0];
    rr_found = 1'b0;
    rr_off   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!rr_found && req_scan[0]) begin
        rr_found = 1'b1;
        rr_off   = IDW'(i);
      end
      req_scan = req_scan >> 1;
    end
    rr_sum = SUMW'(last_grant_q) + SUMW'(rr_off) + SUMW'(1);
    if (rr_sum >= SUMW'(NUM_PORTS)) rr_sum = rr_sum - SUMW'(NUM_PORTS);
    rr_pick = IDW'(rr_sum);
  end

  // Next-state and datapath steering
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pkt_count_d  = pkt_count_q;
    beat_cnt_d   = beat_cnt_q;
    overlength_d = overlength_q;
    m_tdata      = sel_data;
    m_tstrb      = sel_strb;
    m_tvalid     = 1'b0;
    m_tlast      = 1'b0;
    s_tready     = '0;
    xfer         = 1'b0;
    case (state_q)
      IDLE: begin
        if (|s_tvalid) begin
          grant_d = rr_pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        m_tvalid = sel_valid;
        m_tlast  = sel_last;
        s_tready = NUM_PORTS'(m_tready) << grant_q;
        xfer     = sel_valid & m_tready;
        if (xfer) begin
          if (sel_last) begin
            last_grant_d = grant_q;
            pkt_count_d  = pkt_count_q + CW'(1);
            beat_cnt_d   = '0;
            state_d      = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
            if (beat_cnt_q == CW'(MAX_PKT_BEATS - 1)) overlength_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDW'(NUM_PORTS - 1);
      pkt_count_q  <= '0;
      beat_cnt_q   <= '0;
      overlength_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pkt_count_q  <= pkt_count_d;
      beat_cnt_q   <= beat_cnt_d;
      overlength_q <= overlength_d;
    end
  end

  assign m_tid      = grant_q;
  assign pkt_count  = pkt_count_q;
  assign overlength = overlength_q;

endmodule

// File: tb/tb_axis_capture_arbiter.sv
// Bench for axis_capture_arbiter: per-port packet queues drive the slaves, and a
// packet-level round-robin reference model predicts every output each cycle.
module tb_axis_capture_arbiter;
  localparam int unsigned NP   = 4;
  localparam int unsigned W    = 32;
  localparam int unsigned SW   = W / 8;
  localparam int unsigned MAXB = 4;
  localparam int unsigned IDW  = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [NP*W-1:0]  s_tdata;
  logic [NP*SW-1:0] s_tstrb;
  logic [NP-1:0]    s_tvalid, s_tlast, s_tready;
  logic [W-1:0]     m_tdata;
  logic [SW-1:0]    m_tstrb;
  logic             m_tvalid, m_tlast, m_tready;
  logic [IDW-1:0]   m_tid;
  logic [15:0]      pkt_count;
  logic             overlength;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [SW-1:0] s;
    logic          l;
  } beat_t;

  beat_t       q[NP][$];
  logic [W-1:0]  src_d[NP];
  logic [SW-1:0] src_s[NP];
  logic          src_v[NP];
  logic          src_l[NP];
  bit            hs[NP];

  for (genvar gk = 0; gk < NP; gk++) begin : g_pack
    assign s_tdata[gk*W +: W]   = src_d[gk];
    assign s_tstrb[gk*SW +: SW] = src_s[gk];
    assign s_tvalid[gk]         = src_v[gk];
    assign s_tlast[gk]          = src_l[gk];
  end

  axis_capture_arbiter #(
    .NUM_PORTS(NP), .AXIS_WIDTH(W), .MAX_PKT_BEATS(MAXB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .m_tid(m_tid), .pkt_count(pkt_count), .overlength(overlength)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          gap_en;
  int          rdy_mode;
  logic [15:0] pk_loaded;
  bit          md_busy;
  int          md_g, md_last, md_beats;
  logic [15:0] md_pkts;
  logic        md_ovl;
  bit          dut_in_pkt;
  int          dut_order[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_pkt(input int port, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = $urandom;
      b.s = ($urandom_range(3) == 0) ? '0 : SW'($urandom);
      b.l = (i == len - 1);
      q[port].push_back(b);
    end
    pk_loaded = pk_loaded + 16'd1;
  endtask

  // Sources: retire the beat accepted at the last edge, present the next (with optional gaps)
  task automatic drive();
    for (int k = 0; k < NP; k++) begin
      if (hs[k]) void'(q[k].pop_front());
      if (q[k].size() == 0) begin
        src_v[k] = 1'b0;
        src_l[k] = 1'b0;
      end else begin
        if (!(src_v[k] && !hs[k])) src_v[k] = gap_en ? ($urandom_range(3) != 0) : 1'b1;
        src_d[k] = q[k][0].d;
        src_s[k] = q[k][0].s;
        src_l[k] = q[k][0].l;
      end
    end
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'($urandom_range(1));
      default: m_tready = ~m_tready;
    endcase
  endtask

  // Compare outputs with the reference model, then advance the model over the coming edge
  task automatic monitor();
    logic [NP-1:0] er, t;
    bit            found;
    int            idx;
    if (!rst_n) begin
      check("rst_s_tready", 64'(s_tready), 64'(0));
      check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
      check("rst_pkt_count", 64'(pkt_count), 64'(0));
      check("rst_overlength", 64'(overlength), 64'(0));
      check("rst_m_tid", 64'(m_tid), 64'(0));
      md_busy = 0; md_g = 0; md_last = NP - 1; md_beats = 0;
      md_pkts = '0; md_ovl = 1'b0; dut_in_pkt = 0;
      for (int k = 0; k < NP; k++) hs[k] = 0;
      return;
    end
    er = md_busy ? (NP'(m_tready) << md_g) : '0;
    check("s_tready", 64'(s_tready), 64'(er));
    check("m_tvalid", 64'(m_tvalid), 64'(md_busy && src_v[md_g]));
    if (md_busy) begin
      check("m_tid", 64'(m_tid), 64'(md_g));
      if (src_v[md_g])
        check("m_beat", 64'({m_tdata, m_tstrb, m_tlast}),
              64'({src_d[md_g], src_s[md_g], src_l[md_g]}));
    end
    check("pkt_count", 64'(pkt_count), 64'(md_pkts));
    check("overlength", 64'(overlength), 64'(md_ovl));
    if (m_tvalid && m_tready) begin
      if (!dut_in_pkt) dut_order.push_back(int'(m_tid));
      dut_in_pkt = !m_tlast;
    end
    for (int k = 0; k < NP; k++) begin
      t = s_tready >> k;
      hs[k] = src_v[k] && t[0];
    end
    if (!md_busy) begin
      found = 0;
      for (int i = 1; i <= NP; i++) begin
        idx = (md_last + i) % NP;
        if (!found && src_v[idx]) begin
          found = 1; md_busy = 1; md_g = idx;
        end
      end
    end else if (src_v[md_g] && m_tready) begin
      if (src_l[md_g]) begin
        md_pkts = md_pkts + 16'd1; md_last = md_g; md_busy = 0; md_beats = 0;
      end else begin
        if (md_beats == MAXB - 1) md_ovl = 1'b1;
        md_beats++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    monitor();
  endtask

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < NP; k++) s += q[k].size();
    return s;
  endfunction

  task automatic drain(input int maxc);
    int n = 0;
    while (pending() != 0 && n < maxc) begin
      step();
      n++;
    end
    if (n >= maxc) check("drain_timeout", 64'(1), 64'(0));
    repeat (2) step();
  endtask

  task automatic check_order(input string tag, input int exp[$]);
    check({tag, "_count"}, 64'(dut_order.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < dut_order.size(); i++)
      check(tag, 64'(dut_order[i]), 64'(exp[i]));
  endtask

  initial begin
    int n;
    logic [15:0] base;
    rst_n = 1'b0; m_tready = 1'b0; gap_en = 0; rdy_mode = 0; pk_loaded = '0;
    for (int k = 0; k < NP; k++) begin
      src_v[k] = 1'b0; src_l[k] = 1'b0; src_d[k] = '0; src_s[k] = '0; hs[k] = 0;
    end
    repeat (3) step();
    rst_n = 1'b1;
    monitor();

    // Four 3-beat packets all requesting at once
    for (int k = 0; k < NP; k++) load_pkt(k, 3);
    dut_order.delete();
    step();
    n = 0;
    while (pkt_count != 16'd4 && n < 100) begin step(); n++; end
    check("rr4_cycles", 64'(n), 64'(16));
    check("rr4_pkts", 64'(pkt_count), 64'(4));
    check_order("rr4_order", '{0, 1, 2, 3});
    drain(50);

    // Sink ready toggling every cycle
    rdy_mode = 2;
    load_pkt(1, 4);
    drain(100);
    check("toggle_pkts", 64'(pkt_count), 64'(pk_loaded));

    // Overlength packet
    rdy_mode = 0;
    check("ovl_before", 64'(overlength), 64'(0));
    load_pkt(0, 6);
    drain(100);
    check("ovl_after", 64'(overlength), 64'(1));
    check("ovl_pkts", 64'(pkt_count), 64'(pk_loaded));

    // Back-to-back single-beat packets from one port
    base = pkt_count;
    for (int i = 0; i < 10; i++) load_pkt(1, 1);
    step();
    n = 0;
    while (pkt_count != base + 16'd10 && n < 100) begin step(); n++; end
    check("single_cycles", 64'(n), 64'(20));
    check("single_pkts", 64'(pkt_count - base), 64'(10));
    drain(50);

    // Requests during a packet wait; next grant follows the round-robin pointer
    dut_order.delete();
    load_pkt(2, 5);
    n = 0;
    while (q[2].size() > 3 && n < 50) begin step(); n++; end
    load_pkt(0, 2);
    load_pkt(3, 1);
    drain(100);
    check_order("hold_order", '{2, 3, 0});
    check("hold_pkts", 64'(pkt_count), 64'(pk_loaded));

    // Reset in the middle of a port 3 packet
    load_pkt(3, 6);
    n = 0;
    while (q[3].size() > 4 && n < 50) begin step(); n++; end
    check("rst_setup", 64'(q[3].size()), 64'(4));
    rst_n = 1'b0;
    for (int k = 0; k < NP; k++) hs[k] = 0;
    pk_loaded = 16'd1;
    load_pkt(0, 2);
    repeat (2) step();
    rst_n = 1'b1;
    check("rel_m_tvalid", 64'(m_tvalid), 64'(0));
    check("rel_pkt_count", 64'(pkt_count), 64'(0));
    monitor();
    step();
    check("rel_first_grant", 64'(m_tid), 64'(0));
    drain(100);
    check("rel_pkts", 64'(pkt_count), 64'(pk_loaded));

    // Randomized traffic with valid gaps and random backpressure
    gap_en = 1;
    rdy_mode = 1;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NP; k++)
        if (q[k].size() < 4 && $urandom_range(7) == 0) load_pkt(k, 1 + $urandom_range(5));
      step();
    end
    drain(3000);
    check("rand_pkts", 64'(pkt_count), 64'(pk_loaded));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_capture_arbiter.md
AXIS_CAPTURE_ARBITER -- requirements
Module: axis_capture_arbiter

Interface — parameters
REQ-001 The block SHALL provide parameter NUM_PORTS, default 4, giving the number of AXI4-Stream slave ports (legal range 2..8).
REQ-002 The block SHALL provide parameter AXIS_WIDTH, default 64, giving the tdata width in bits (multiple of 8).
REQ-003 The block SHALL provide parameter MAX_PKT_BEATS, default 256, giving the beat count at which a packet is flagged overlength.
REQ-004 The block SHALL define localparam IDW = clog2(NUM_PORTS), minimum 1.

Interface — ports
REQ-005 The block SHALL have ports, in this order:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- s_tdata  in  NUM_PORTS*AXIS_WIDTH  slave data; port k occupies bits [k*AXIS_WIDTH +: AXIS_WIDTH].
- s_tstrb  in  NUM_PORTS*AXIS_WIDTH/8  slave byte strobes, same packing.
- s_tvalid  in  NUM_PORTS  slave valid, one bit per port.
- s_tlast  in  NUM_PORTS  slave last, one bit per port.
- s_tready  out  NUM_PORTS  slave ready, one bit per port.
- m_tdata  out  AXIS_WIDTH  master data to the capture sink.
- m_tstrb  out  AXIS_WIDTH/8  master strobes.
- m_tvalid  out  1  master valid.
- m_tlast  out  1  master last.
- m_tready  in  1  master ready.
- m_tid  out  IDW  index of the granted source port.
- pkt_count  out  16  count of completed output packets; wraps at 16 bits.
- overlength  out  1  sticky flag for an overlength packet.

Function
REQ-006 The arbiter SHALL implement a two-state FSM: IDLE and BUSY.
REQ-007 Arbitration in IDLE SHALL work as follows:
- If any s_tvalid bit is 1, the FSM SHALL latch grant for the first requesting port found scanning upward, modulo NUM_PORTS, from last_grant+1.
- The FSM SHALL then enter BUSY on the next clock edge.
- If no s_tvalid bit is 1, the FSM SHALL stay in IDLE.
REQ-008 In IDLE, all s_tready bits SHALL be 0 and m_tvalid SHALL be 0; arbitration latency is therefore exactly one cycle.
REQ-009 In BUSY, the master outputs SHALL be driven combinationally from the granted port:
- m_tdata, m_tstrb, m_tvalid and m_tlast SHALL equal the granted port's signals.
- s_tready[grant] SHALL equal m_tready.
- All other s_tready bits SHALL be 0.
- m_tid SHALL equal grant.
REQ-010 A beat SHALL transfer only when m_tvalid and m_tready are both 1.
REQ-011 Grant SHALL be held for the whole packet; no port switch is permitted before the tlast beat transfers.
REQ-012 When the tlast beat transfers in BUSY, the block SHALL:
- set last_grant to grant;
- increment pkt_count by 1 (wrapping at 16 bits);
- clear the beat counter;
- return to IDLE.
REQ-013 A 16-bit beat counter SHALL increment on each transferred non-last beat.
REQ-014 When a beat transfers while the beat counter equals MAX_PKT_BEATS-1 and tlast is 0, overlength SHALL be set to 1. It SHALL remain 1 until reset; forwarding SHALL continue unchanged.
REQ-015 If the granted port deasserts tvalid mid-packet, the FSM SHALL remain in BUSY with grant unchanged, passing m_tvalid=0.
REQ-016 Requests arriving on other ports during BUSY SHALL be ignored until the next IDLE; their data SHALL not be consumed.
REQ-017 With only one requester, that port SHALL be re-granted after each one-cycle IDLE bubble.
REQ-018 A single-beat packet (tvalid and tlast together) SHALL complete in one BUSY cycle when m_tready is 1.
REQ-019 The block SHALL not modify tdata or tstrb; zero-strobe beats SHALL pass through unchanged.

Reset
REQ-020 While rst_n is 0, the block SHALL hold: state IDLE, grant 0, last_grant NUM_PORTS-1, pkt_count 0, beat counter 0, overlength 0, m_tvalid 0, all s_tready 0.
REQ-021 Reset asserted mid-packet SHALL abandon that packet immediately; no further beats are forwarded, and arbitration after release SHALL start from port 0.
REQ-022 Reset release SHALL be synchronised by the integrator; the block SHALL take its first action on the first clk edge with rst_n at 1.

Verification
REQ-023 Ports 0..3 each send one 3-beat packet, all requesting at cycle 0, m_tready=1 -> m_tid order 0,1,2,3; 16 total beats including 4 IDLE bubbles; pkt_count=4.
REQ-024 Port 2 is mid-packet at beat 2 of 5 when port 0 asserts tvalid -> s_tready[0] stays 0 until port 2's tlast transfers; the next grant is port 3 if it is requesting, else port 0.
REQ-025 m_tready toggles 1,0,1,0 during a 4-beat packet from port 1 -> output beats arrive in order with no loss or duplication, and s_tready[1] mirrors m_tready.
REQ-026 With MAX_PKT_BEATS=4, port 0 sends 6 beats with tlast on beat 6 -> overlength rises after beat 4 transfers, all 6 beats are forwarded, and pkt_count=1.
REQ-027 rst_n pulses low for 2 cycles during beat 2 of a port 3 packet -> m_tvalid=0 and pkt_count=0 on release; with ports 0 and 3 requesting, the first grant after release is port 0.
REQ-028 A single-beat packet from port 1, repeated 10 times with m_tready=1 -> one beat every 2 cycles and pkt_count=10.
